// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and helpers.
// Imported by the combinational core and the registered top.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_RSVD = 3'b111
  } alu_op_e;

endpackage

// File: rtl/riscv_alu_comb.sv
// Combinational ALU core: result = op(a, b), zero = (result == 0).
// Ports: a, b, op in; result, zero out. No clock, no state.
module riscv_alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [WIDTH-1:0]    result,
  output logic                zero
);

  logic slt;
  logic sltu;

  // True signed compare; the sign of (a-b) is wrong on overflow.
  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
      ALU_RSVD: result = '0;
      // Unknown op propagates rather than masking to a value.
      default:  result = 'x;
    endcase
  end

  assign zero = ~|result;

endmodule

// File: rtl/riscv_alu.sv
// RV32 execute-stage ALU with combinational and registered outputs.
// Ports: clk, rst_n, a, b, op, in_valid -> result, zero, result_q, zero_q, out_valid.
module riscv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  input  logic                in_valid,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic [WIDTH-1:0]    result_q,
  output logic                zero_q,
  output logic                out_valid
);

  riscv_alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .zero   (zero)
  );

  // out_valid pulses per capture; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result_q <= result;
        zero_q   <= zero;
      end
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: vector table for the
// combinational path, directed sequences for the register stage.
module tb_riscv_alu;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_z;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        in_valid;
  logic [31:0] result;
  logic        zero;
  logic [31:0] result_q;
  logic        zero_q;
  logic        out_valid;

  int checks;
  int errors;

  vec_t vecs[$];

  riscv_alu #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
    .result_q  (result_q),
    .zero_q    (zero_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = 3'b000;

    vecs.push_back(vec_t'{"add_5_3",   3'b000, 32'd5, 32'd3, 32'd8, 1'b0});
    vecs.push_back(vec_t'{"add_wrap0", 3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"add_ovf",   3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0});
    vecs.push_back(vec_t'{"sub_5_9",   3'b001, 32'd5, 32'd9, 32'hFFFFFFFC, 1'b0});
    vecs.push_back(vec_t'{"sub_2_2",   3'b001, 32'd2, 32'd2, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"sub_min",   3'b001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0});
    vecs.push_back(vec_t'{"and",       3'b010, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1'b0});
    vecs.push_back(vec_t'{"or",        3'b011, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 1'b0});
    vecs.push_back(vec_t'{"xor",       3'b100, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0});
    vecs.push_back(vec_t'{"xor_same",  3'b100, 32'h12345678, 32'h12345678, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"slt_m1_1",  3'b101, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0});
    vecs.push_back(vec_t'{"slt_1_m1",  3'b101, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"slt_m5_m3", 3'b101, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'd1, 1'b0});
    vecs.push_back(vec_t'{"slt_m3_m5", 3'b101, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"slt_min",   3'b101, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0});
    vecs.push_back(vec_t'{"slt_max",   3'b101, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"sltu_big",  3'b110, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"sltu_1_big",3'b110, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0});
    vecs.push_back(vec_t'{"sltu_min",  3'b110, 32'h80000000, 32'h7FFFFFFF, 32'd0, 1'b1});
    vecs.push_back(vec_t'{"rsvd",      3'b111, 32'hDEADBEEF, 32'h1234, 32'd0, 1'b1});

    // Reset state while rst_n is low.
    #2;
    chk("rst_result_q", result_q, 32'd0);
    chk("rst_zero_q", {31'd0, zero_q}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Combinational path works regardless of reset.
    foreach (vecs[i]) begin
      op = vecs[i].op;
      a  = vecs[i].a;
      b  = vecs[i].b;
      #1;
      chk({vecs[i].name, "_r"}, result, vecs[i].exp_r);
      chk({vecs[i].name, "_z"}, {31'd0, zero}, {31'd0, vecs[i].exp_z});
    end

    // Release reset away from an edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Capture ADD 5+3.
    @(negedge clk);
    op = 3'b000; a = 32'd5; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("cap_result_q", result_q, 32'd8);
    chk("cap_zero_q", {31'd0, zero_q}, 32'd0);
    chk("cap_out_valid", {31'd0, out_valid}, 32'd1);

    // Idle cycle: data holds, valid drops.
    @(negedge clk);
    in_valid = 1'b0; op = 3'b001; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    chk("hold_result_q", result_q, 32'd8);
    chk("hold_zero_q", {31'd0, zero_q}, 32'd0);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);

    // Capture a zero result (2-2).
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("capz_result_q", result_q, 32'd0);
    chk("capz_zero_q", {31'd0, zero_q}, 32'd1);
    chk("capz_out_valid", {31'd0, out_valid}, 32'd1);

    // Load a non-zero value, then reset mid-cycle.
    @(negedge clk);
    op = 3'b011; a = 32'hA5A50000; b = 32'h00005A5A;
    @(posedge clk); #1;
    chk("pre_rst_result_q", result_q, 32'hA5A55A5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result_q", result_q, 32'd0);
    chk("async_rst_zero_q", {31'd0, zero_q}, 32'd0);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_comb_result", result, 32'hA5A55A5A);

    // First edge after release is a normal capture.
    @(negedge clk);
    rst_n = 1'b1;
    op = 3'b101; a = 32'h80000000; b = 32'h7FFFFFFF;
    @(posedge clk); #1;
    chk("post_rst_result_q", result_q, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_idle_q", result_q, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
